// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file geometry shared by the write-port logic.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a rotating priority pointer.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic            hold,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   input  logic            advance
);
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_nxt;
   logic [ID_W:0]   pos;
   logic            found;

   // Walk ptr, ptr+1, ... modulo N; the first valid request wins.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      pos    = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (ID_W+1)'(k);
         if (pos >= (ID_W+1)'(N)) pos = pos - (ID_W+1)'(N);
         if (!found && req[pos[ID_W-1:0]]) begin
            found  = 1'b1;
            gnt_id = pos[ID_W-1:0];
         end
      end
      if (found && !hold && !reset) gnt[gnt_id] = 1'b1;
   end

   assign ptr_nxt = (gnt_id == ID_W'(N-1)) ? '0 : gnt_id + ID_W'(1);

   always_ff @(posedge clk) begin
      if (reset) ptr <= '0;
      else if (advance) ptr <= ptr_nxt;
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between requesters.
// REGFILE_ARB_ZERO_GUARD_EN suppresses the write enable for register 0.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       rf_hold,
   output logic                       wr_enable,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               xfer;
   logic               we_nxt;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .hold    (rf_hold),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .advance (xfer)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef REGFILE_ARB_ZERO_GUARD_EN
   // Handshake still completes so the requester is not stalled on r0.
   assign we_nxt = xfer && (sel_addr != ADDR_W'(ZERO_REG));
`else
   assign we_nxt = xfer;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_enable <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         grant_id  <= '0;
      end else begin
         wr_enable <= we_nxt;
         if (xfer) begin
            wr_addr  <= sel_addr;
            wr_data  <= sel_data;
            grant_id <= gnt_id;
         end
      end
   end
endmodule
